// File: rtl/sequential_updown_counter.sv
// Prescaled up/down counter with wrap/saturate/one-shot terminal handling.
// Optional status overlay on io_out[15:14] when SEQ_STATUS_EN is defined.
//
// state | meaning
// RUN   | counting: prescaler advances and ticks step the counter while en=1
// DONE  | one-shot terminal reached: counter and prescaler frozen until load/rst
module sequential_updown_counter #(
   parameter int CTR_WIDTH = 16,
   parameter int PRESCALE  = 10
) (
   input  logic        clk,
   input  logic [15:0] io_in,
   output logic [15:0] io_out,
   output logic [15:0] io_oeb
);

   localparam int PW = (PRESCALE > 0) ? PRESCALE : 1;
   localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [CTR_WIDTH-1:0]   ctr_q, ctr_d;
   logic [PW-1:0]          pre_q, pre_d;
   logic                   tc_q, tc_d;

   logic                   rst, en, dir, sat, load, oneshot;
   logic [CTR_WIDTH-1:0]   load_val;
   logic [PW-1:0]          pre_inc;
   logic                   tick, term;
   logic [1:0]             unused_io;

   assign rst       = io_in[0];
   assign en        = io_in[1];
   assign dir       = io_in[2];
   assign sat       = io_in[3];
   assign load      = io_in[4];
   assign oneshot   = io_in[5];
   assign unused_io = io_in[7:6];
   assign load_val  = CTR_WIDTH'(io_in[15:8]);

   // With no prescaler every enabled cycle is a tick and pre_q stays at zero.
   assign pre_inc = (PRESCALE == 0) ? '0 : pre_q + 1'b1;
   assign tick    = (PRESCALE == 0) ? 1'b1 : (pre_q == '1);
   assign term    = dir ? (ctr_q == '0) : (ctr_q == CTR_MAX);

   always_comb begin
      ctr_d   = ctr_q;
      pre_d   = pre_q;
      tc_d    = tc_q;
      state_d = state_q;
      if (load) begin
         ctr_d   = load_val;
         pre_d   = '0;
         tc_d    = 1'b0;
         state_d = RUN;
      end else if (en && (state_q == RUN)) begin
         pre_d = pre_inc;
         if (tick) begin
            if (term) begin
               tc_d = 1'b1;
               if (oneshot) begin
                  state_d = DONE;
               end else if (!sat) begin
                  ctr_d = dir ? CTR_MAX : '0;
               end
            end else begin
               ctr_d = dir ? (ctr_q - 1'b1) : (ctr_q + 1'b1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctr_q   <= '0;
         pre_q   <= '0;
         tc_q    <= 1'b0;
         state_q <= RUN;
      end else begin
         ctr_q   <= ctr_d;
         pre_q   <= pre_d;
         tc_q    <= tc_d;
         state_q <= state_d;
      end
   end

   assign io_oeb = 16'hFFFF;

`ifdef SEQ_STATUS_EN
   logic [15:0] ctr_ext;
   assign ctr_ext = 16'(ctr_q);
   assign io_out  = {tc_q, (state_q == DONE), ctr_ext[13:0]};
`else
   logic unused_tc;
   assign unused_tc = tc_q;
   assign io_out    = 16'(ctr_q);
`endif

endmodule
